// File: rtl/pit_multichannel.sv
`default_nettype none
// ============================================================================
//  Module   : pit_multichannel
//  Purpose  : Multi-channel programmable interval timer on the IPIF slave bus.
//             Each channel has CTRL / LOAD / COUNT registers, a prescaler and
//             a pending bit; pending bits are gathered in a W1C IRQ_STATUS
//             register and combined (masked by IE) onto one interrupt line.
//  Revision : 1.0  initial release
// ============================================================================
module pit_multichannel #(
  parameter int C_NUM_CH     = 4,
  parameter int C_CNT_WIDTH  = 32,
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_NUM_REG    = 3*C_NUM_CH+1
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Resetn,
  input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
  output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_Error,
  output logic                      IP_Interupt
);

  localparam int STAT_REG = 3*C_NUM_CH;

  // Register-number indexed selects (CE bit C_NUM_REG-1 addresses reg 0)
  logic [C_NUM_REG-1:0]    rd_sel;
  logic [C_NUM_REG-1:0]    wr_sel;
  logic [C_NUM_REG-1:0]    wr_en;
  logic                    rd_any;
  logic                    wr_any;
  logic                    rd_onehot;
  logic                    wr_onehot;
  logic [C_SLV_DWIDTH-1:0] be_mask;
  logic [C_SLV_DWIDTH-1:0] reg_val [C_NUM_REG];
  logic [C_SLV_DWIDTH-1:0] rd_data;
  logic [C_NUM_CH-1:0]     pend_vec;
  logic [C_NUM_CH-1:0]     ie_vec;

  genvar gi;

  generate
    for (gi = 0; gi < C_NUM_REG; gi++) begin : g_sel
      assign rd_sel[gi] = Bus2IP_RdCE[C_NUM_REG-1-gi];
      assign wr_sel[gi] = Bus2IP_WrCE[C_NUM_REG-1-gi];
    end
    for (gi = 0; gi < C_SLV_DWIDTH/8; gi++) begin : g_be
      assign be_mask[8*gi +: 8] = {8{Bus2IP_BE[gi]}};
    end
  endgenerate

  assign rd_any    = |Bus2IP_RdCE;
  assign wr_any    = |Bus2IP_WrCE;
  assign rd_onehot = $onehot(Bus2IP_RdCE);
  assign wr_onehot = $onehot(Bus2IP_WrCE);

  // A malformed (multi-hot) write is discarded entirely
  assign wr_en = wr_onehot ? wr_sel : '0;

  assign IP2Bus_RdAck = rd_any;
  assign IP2Bus_WrAck = wr_any;
  assign IP2Bus_Error = (rd_any & ~rd_onehot) | (wr_any & ~wr_onehot);

  generate
    for (gi = 0; gi < C_NUM_CH; gi++) begin : g_ch
      localparam int R_CTRL  = 3*gi;
      localparam int R_LOAD  = 3*gi + 1;
      localparam int R_COUNT = 3*gi + 2;

      logic                    en_q;
      logic                    ie_q;
      logic                    reload_q;
      logic [15:0]             prescale_q;
      logic [15:0]             psc_q;
      logic [C_CNT_WIDTH-1:0]  load_q;
      logic [C_CNT_WIDTH-1:0]  count_q;
      logic                    pending_q;
      logic [C_SLV_DWIDTH-1:0] ctrl_word;
      logic [C_SLV_DWIDTH-1:0] ctrl_new;
      logic [C_SLV_DWIDTH-1:0] load_ext;
      logic [C_SLV_DWIDTH-1:0] count_ext;
      logic [C_SLV_DWIDTH-1:0] load_merge;
      logic [C_SLV_DWIDTH-1:0] count_merge;
      logic                    tick;
      logic                    expire;
      logic                    clr;

      assign ctrl_word   = {8'h00, prescale_q, 5'b00000, reload_q, ie_q, en_q};
      assign ctrl_new    = (ctrl_word & ~be_mask) | (Bus2IP_Data & be_mask);
      assign load_ext    = C_SLV_DWIDTH'(load_q);
      assign count_ext   = C_SLV_DWIDTH'(count_q);
      assign load_merge  = (load_ext  & ~be_mask) | (Bus2IP_Data & be_mask);
      assign count_merge = (count_ext & ~be_mask) | (Bus2IP_Data & be_mask);

      assign tick   = en_q && (psc_q == prescale_q);
      // A LOAD write overrides the tick, so it also suppresses the expiry
      assign expire = tick && (count_q == C_CNT_WIDTH'(1)) && !wr_en[R_LOAD];
      assign clr    = wr_en[STAT_REG] & Bus2IP_Data[gi] & be_mask[gi];

      // Control fields and prescaler; a CTRL write restarts the prescaler
      always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
          en_q       <= 1'b0;
          ie_q       <= 1'b0;
          reload_q   <= 1'b0;
          prescale_q <= '0;
          psc_q      <= '0;
        end else begin
          if (wr_en[R_CTRL]) begin
            en_q       <= ctrl_new[0];
            ie_q       <= ctrl_new[1];
            reload_q   <= ctrl_new[2];
            prescale_q <= ctrl_new[23:8];
            psc_q      <= '0;
          end else if (en_q) begin
            psc_q <= tick ? 16'd0 : psc_q + 16'd1;
          end
        end
      end

      // LOAD register and down-counter; counter stops at 0, never wraps
      always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
          load_q  <= '0;
          count_q <= '0;
        end else begin
          if (wr_en[R_LOAD]) begin
            load_q  <= load_merge[C_CNT_WIDTH-1:0];
            count_q <= count_merge[C_CNT_WIDTH-1:0];
          end else if (tick && (count_q != '0)) begin
            if (count_q == C_CNT_WIDTH'(1))
              count_q <= reload_q ? load_q : '0;
            else
              count_q <= count_q - C_CNT_WIDTH'(1);
          end
        end
      end

      // Pending bit: expiry sets it and beats a simultaneous W1C
      always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn)
          pending_q <= 1'b0;
        else
          pending_q <= expire | (pending_q & ~clr);
      end

      assign reg_val[R_CTRL]  = ctrl_word;
      assign reg_val[R_LOAD]  = load_ext;
      assign reg_val[R_COUNT] = count_ext;
      assign pend_vec[gi]     = pending_q;
      assign ie_vec[gi]       = ie_q;
    end
  endgenerate

  assign reg_val[STAT_REG] = C_SLV_DWIDTH'(pend_vec);

  // Read-data mux; zero unless exactly one read CE is active
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < C_NUM_REG; r++) begin
      if (rd_sel[r])
        rd_data = rd_data | reg_val[r];
    end
    IP2Bus_Data = rd_onehot ? rd_data : '0;
  end

  assign IP_Interupt = |(pend_vec & ie_vec);

endmodule
`default_nettype wire

// File: tb/tb_pit_multichannel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pit_multichannel
//  Purpose  : Directed self-checking bench for pit_multichannel (4 channels,
//             32-bit counters). Inputs change 1 ns after the rising edge;
//             combinational bus outputs are sampled before the next edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pit_multichannel;

  localparam int NREG = 13;

  logic             clk;
  logic             resetn;
  logic [31:0]      data;
  logic [3:0]       be;
  logic [NREG-1:0]  rdce;
  logic [NREG-1:0]  wrce;
  logic [31:0]      rdata;
  logic             rdack;
  logic             wrack;
  logic             err;
  logic             irq;

  int n_pass;
  int n_total;

  pit_multichannel #(
    .C_NUM_CH     (4),
    .C_CNT_WIDTH  (32),
    .C_SLV_DWIDTH (32)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (resetn),
    .Bus2IP_Data   (data),
    .Bus2IP_BE     (be),
    .Bus2IP_RdCE   (rdce),
    .Bus2IP_WrCE   (wrce),
    .IP2Bus_Data   (rdata),
    .IP2Bus_RdAck  (rdack),
    .IP2Bus_WrAck  (wrack),
    .IP2Bus_Error  (err),
    .IP_Interupt   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREG-1:0] ce_of(input int r);
    logic [NREG-1:0] v;
    v = '0;
    v[NREG-1-r] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int r, input logic [31:0] d, input logic [3:0] b);
    wrce = ce_of(r);
    data = d;
    be   = b;
    @(posedge clk);
    #1;
    wrce = '0;
  endtask

  task automatic rd(input int r, output logic [31:0] d);
    rdce = ce_of(r);
    #1;
    d = rdata;
    rdce = '0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
    n_total++;
    if (rdack !== 1'b0 || wrack !== 1'b0) $display("FAIL reset_acks: got rd=%b wr=%b expected 0 0", rdack, wrack); else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
    n_total++;
    if (rdata !== 32'h0) $display("FAIL reset_data: got %h expected 0", rdata); else n_pass++;
    resetn = 1'b1;
    step();
    for (int r = 0; r < NREG; r++) begin
      rd(r, v);
      n_total++;
      if (v !== 32'h0) $display("FAIL reset_reg%0d: got %h expected 0", r, v); else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic [31:0] exp_seq [4] = '{32'd2, 32'd1, 32'd0, 32'd0};
    wr(1, 32'd2, 4'hF);
    wr(0, 32'h1, 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd(2, v);
      n_total++;
      if (v !== exp_seq[i]) $display("FAIL oneshot_count[%0d]: got %0d expected %0d", i, v, exp_seq[i]); else n_pass++;
      step();
    end
    rd(12, v);
    n_total++;
    if (v !== 32'h1) $display("FAIL oneshot_status: got %h expected 1", v); else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL oneshot_irq_masked: got %b expected 0", irq); else n_pass++;
    wr(0, 32'h0, 4'hF);
    wr(12, 32'h1, 4'hF);
  endtask

  task automatic test_reload_and_w1c_collision();
    logic [31:0] v;
    logic [31:0] exp_seq [7] = '{32'd3, 32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3};
    wr(4, 32'd3, 4'hF);
    wr(3, 32'h5, 4'hF);
    for (int i = 0; i < 7; i++) begin
      rd(5, v);
      n_total++;
      if (v !== exp_seq[i]) $display("FAIL reload_count[%0d]: got %0d expected %0d", i, v, exp_seq[i]); else n_pass++;
      if (i == 3) begin
        rd(12, v);
        n_total++;
        if (v !== 32'h2) $display("FAIL reload_status_first: got %h expected 2", v); else n_pass++;
      end
      if (i < 6) step();
    end
    // W1C on an edge with no expiry clears the bit
    wr(12, 32'h2, 4'hF);
    rd(12, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL w1c_clear: got %h expected 0", v); else n_pass++;
    rd(5, v);
    n_total++;
    if (v !== 32'd2) $display("FAIL w1c_count: got %0d expected 2", v); else n_pass++;
    step();
    // W1C in the very cycle ch1 reloads: the set wins
    wr(12, 32'h2, 4'hF);
    rd(12, v);
    n_total++;
    if (v !== 32'h2) $display("FAIL w1c_collision_status: got %h expected 2", v); else n_pass++;
    rd(5, v);
    n_total++;
    if (v !== 32'd3) $display("FAIL w1c_collision_count: got %0d expected 3", v); else n_pass++;
    wr(3, 32'h0, 4'hF);
    wr(12, 32'h2, 4'hF);
  endtask

  task automatic test_prescale_irq();
    logic [31:0] v;
    wr(7, 32'd2, 4'hF);
    wr(6, 32'h0000_0307, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3 || k == 4) begin
        rd(8, v);
        n_total++;
        if (v !== ((k == 3) ? 32'd2 : 32'd1)) $display("FAIL psc_count_k%0d: got %0d expected %0d", k, v, (k == 3) ? 2 : 1); else n_pass++;
      end
      if (k >= 7) begin
        n_total++;
        if (irq !== (k == 8)) $display("FAIL psc_irq_k%0d: got %b expected %b", k, irq, (k == 8)); else n_pass++;
      end
    end
    wr(12, 32'h4, 4'hF);
    n_total++;
    if (irq !== 1'b0) $display("FAIL psc_irq_cleared: got %b expected 0", irq); else n_pass++;
    for (int k = 10; k <= 16; k++) begin
      step();
      if (k >= 15) begin
        n_total++;
        if (irq !== (k == 16)) $display("FAIL psc_irq_again_k%0d: got %b expected %b", k, irq, (k == 16)); else n_pass++;
      end
    end
    // Dropping IE masks the line but leaves the pending bit
    wr(6, 32'h0, 4'hF);
    n_total++;
    if (irq !== 1'b0) $display("FAIL ie_mask_irq: got %b expected 0", irq); else n_pass++;
    rd(12, v);
    n_total++;
    if (v !== 32'h4) $display("FAIL ie_mask_pending: got %h expected 4", v); else n_pass++;
    wr(12, 32'h4, 4'hF);
  endtask

  task automatic test_same_cycle_expiry();
    logic [31:0] v;
    // ch0 is enabled one cycle before ch3, so it gets one extra count
    // to make both reach expiry on the same edge.
    wr(1, 32'd6, 4'hF);
    wr(10, 32'd5, 4'hF);
    wr(0, 32'h3, 4'hF);
    wr(9, 32'h3, 4'hF);
    for (int k = 2; k <= 6; k++) begin
      step();
      if (k >= 5) begin
        rd(12, v);
        n_total++;
        if (v !== ((k == 6) ? 32'h9 : 32'h0)) $display("FAIL same_cycle_status_k%0d: got %h expected %h", k, v, (k == 6) ? 9 : 0); else n_pass++;
      end
    end
    n_total++;
    if (irq !== 1'b1) $display("FAIL same_cycle_irq: got %b expected 1", irq); else n_pass++;
    wr(0, 32'h0, 4'hF);
    wr(9, 32'h0, 4'hF);
    wr(12, 32'h9, 4'hF);
  endtask

  task automatic test_bus_rules();
    logic [31:0] v;
    wr(10, 32'h0, 4'hF);
    wr(10, 32'hAABB_CCDD, 4'b0011);
    rdce = ce_of(10);
    #1;
    n_total++;
    if (rdata !== 32'h0000_CCDD) $display("FAIL be_load: got %h expected 0000ccdd", rdata); else n_pass++;
    n_total++;
    if (rdack !== 1'b1 || err !== 1'b0) $display("FAIL read_ack: got ack=%b err=%b expected 1 0", rdack, err); else n_pass++;
    rdce = '0;
    rd(11, v);
    n_total++;
    if (v !== 32'h0000_CCDD) $display("FAIL be_count: got %h expected 0000ccdd", v); else n_pass++;
    // Multi-hot write: acked with error, nothing changes
    wrce = ce_of(10) | ce_of(9);
    data = 32'h1234_5678;
    be   = 4'hF;
    #1;
    n_total++;
    if (wrack !== 1'b1 || err !== 1'b1) $display("FAIL multi_wr_flags: got ack=%b err=%b expected 1 1", wrack, err); else n_pass++;
    step();
    wrce = '0;
    rd(10, v);
    n_total++;
    if (v !== 32'h0000_CCDD) $display("FAIL multi_wr_load: got %h expected 0000ccdd", v); else n_pass++;
    rd(9, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL multi_wr_ctrl: got %h expected 0", v); else n_pass++;
    // COUNT is read-only
    wrce = ce_of(11);
    data = 32'h55;
    #1;
    n_total++;
    if (wrack !== 1'b1 || err !== 1'b0) $display("FAIL count_wr_flags: got ack=%b err=%b expected 1 0", wrack, err); else n_pass++;
    step();
    wrce = '0;
    rd(11, v);
    n_total++;
    if (v !== 32'h0000_CCDD) $display("FAIL count_wr_ignored: got %h expected 0000ccdd", v); else n_pass++;
    // Multi-hot read
    rdce = ce_of(10) | ce_of(11);
    #1;
    n_total++;
    if (rdata !== 32'h0 || err !== 1'b1 || rdack !== 1'b1) $display("FAIL multi_rd: got data=%h err=%b ack=%b expected 0 1 1", rdata, err, rdack); else n_pass++;
    rdce = '0;
    // Unimplemented CTRL bits read back as 0
    wr(3, 32'hFFFF_FFFF, 4'hF);
    rd(3, v);
    n_total++;
    if (v !== 32'h00FF_FF07) $display("FAIL ctrl_mask: got %h expected 00ffff07", v); else n_pass++;
    wr(3, 32'h0, 4'hF);
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    wr(4, 32'd3, 4'hF);
    wr(3, 32'h7, 4'hF);
    repeat (3) step();
    n_total++;
    if (irq !== 1'b1) $display("FAIL midcount_irq_before: got %b expected 1", irq); else n_pass++;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_total++;
    if (irq !== 1'b0) $display("FAIL midcount_irq_after: got %b expected 0", irq); else n_pass++;
    for (int r = 0; r < NREG; r++) begin
      rd(r, v);
      n_total++;
      if (v !== 32'h0) $display("FAIL midcount_reg%0d: got %h expected 0", r, v); else n_pass++;
    end
    step();
    rd(5, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL midcount_frozen: got %h expected 0", v); else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL midcount_irq_stays: got %b expected 0", irq); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    resetn  = 1'b0;
    data    = '0;
    be      = 4'hF;
    rdce    = '0;
    wrce    = '0;
    test_reset();
    test_oneshot();
    test_reload_and_w1c_collision();
    test_prescale_irq();
    test_same_cycle_expiry();
    test_bus_rules();
    test_reset_midcount();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pit_multichannel.md
Name: pit_multichannel

Overview:
- Parametrised multi-channel programmable interval timer behind the IPIF slave bus; successor to the single-channel PIT.
- Adds: N independent channels, configurable counter width, per-channel prescaler, readable live count, and a write-1-to-clear interrupt-status register.
- Drives one combined interrupt line to the system interrupt controller.

Parameters:
- C_NUM_CH, 4: number of timer channels, 1..8.
- C_CNT_WIDTH, 32: counter and LOAD width, 8..32; unused upper data bits read 0.
- C_SLV_DWIDTH, 32: bus data width, fixed at 32.
- C_NUM_REG, 3*C_NUM_CH+1: register count (derived, do not override).

Ports:
- Bus2IP_Clk  in  1  single clock, all logic rising-edge.
- Bus2IP_Resetn  in  1  synchronous active-low reset.
- Bus2IP_Data  in  32  write data.
- Bus2IP_BE  in  4  byte enables; BE[i] gates Data[8i+7:8i].
- Bus2IP_RdCE  in  C_NUM_REG  one-hot read chip-enable; bit C_NUM_REG-1 = reg 0.
- Bus2IP_WrCE  in  C_NUM_REG  one-hot write chip-enable, same ordering.
- IP2Bus_Data  out  32  read data.
- IP2Bus_RdAck  out  1  read acknowledge.
- IP2Bus_WrAck  out  1  write acknowledge.
- IP2Bus_Error  out  1  access error.
- IP_Interupt  out  1  combined level interrupt.

Behaviour:
- Register map, channel n:
  - reg 3n = CTRL: [0] EN, [1] IE, [2] RELOAD, [23:8] PRESCALE; other bits read 0.
  - reg 3n+1 = LOAD.
  - reg 3n+2 = COUNT (read-only; writes acked and ignored).
- Reg 3*C_NUM_CH = IRQ_STATUS: bit n = pending[n]; write 1 clears, write 0 has no effect.
- Reset (Resetn=0 at a clock edge):
  - All CTRL, LOAD, COUNT, prescaler and pending state go to 0.
  - IP_Interupt = 0. Bus outputs follow the combinational rules below (0 with CEs low).
  - Reset mid-count aborts the channel; nothing is retained.
- Bus timing:
  - RdAck = |RdCE and WrAck = |WrCE, combinational, same cycle.
  - IP2Bus_Data is muxed combinationally from the selected register; 0 when no RdCE.
  - Error is asserted with the ack when the CE is not one-hot; the write is discarded and read data = 0.
- Write side effects (all take effect at the clock edge; byte enables honoured on every writable register):
  - Writing LOAD also loads COUNT (only the written bytes); the new value is readable the next cycle.
  - Writing CTRL clears that channel's prescaler counter psc to 0.
- Prescaler:
  - When EN=1, psc increments each cycle.
  - When psc==PRESCALE, a tick fires and psc returns to 0.
  - PRESCALE=0 gives a tick every cycle; EN=0 freezes psc and COUNT.
- Count, on a tick with COUNT!=0:
  - COUNT>1: decrement by 1.
  - COUNT==1, RELOAD=0: COUNT becomes 0 and pending[n] is set (expiry).
  - COUNT==1, RELOAD=1: COUNT becomes LOAD and pending[n] is set. If LOAD==0, COUNT becomes 0 and the expiry still fires.
  - COUNT==0: hold at 0, no event. There is no wrap below 0.
- Pending:
  - Set on expiry regardless of IE.
  - If expiry and a W1C of the same bit occur in one cycle, set wins.
- Write collisions:
  - A LOAD write in the same cycle as a tick: the write wins and no decrement occurs that cycle.
  - A CTRL write and a tick in the same cycle: the new CTRL takes effect from the next cycle, and the tick still applies.
- Interrupt:
  - IP_Interupt = OR over n of (pending[n] & IE[n]), from flops, no added latency.
  - Clearing IE masks the line but keeps pending.
- Channels are fully independent; equal-period channels expire in the same cycle.

Test Plan:
- Ch0 one-shot: LOAD=2, then CTRL=0x1 -> COUNT reads 2,1,0 on consecutive cycles after enable, then holds 0; IRQ_STATUS=0x1; IP_Interupt stays 0.
- Ch1 reload: LOAD=3, CTRL=0x5 -> COUNT sequence 3,2,1,3,2,1,3; pending[1] set every 3 cycles; read IRQ_STATUS=0x2.
- Ch2 prescale + IRQ: LOAD=2, CTRL=0x00000307 -> one decrement per 4 clocks; IP_Interupt rises 8 clocks after enable; write IRQ_STATUS=0x4 -> drops next cycle; rises again 8 clocks later.
- Collision: W1C pending[1] in the exact cycle ch1 reloads -> IRQ_STATUS bit1 stays 1; ch0 and ch3 both with LOAD=5, CTRL=0x3, enabled together -> both bits set in the same cycle.
- Bus rules: LOAD ch3 write 0xAABBCCDD with BE=0011 (prior 0) -> reads 0x0000CCDD; WrCE with two bits set -> WrAck=1, Error=1, no register change; write COUNT -> acked, value unchanged.
- Reset mid-count: ch1 running with reload and IE=1, Resetn=0 for 1 cycle -> next cycle all regs read 0, IP_Interupt=0, COUNT frozen at 0.
